reg_file: RTL and testbench

// - Slave end of the fetch-stage register-read interface: serves two read ports (r1/r2) to
//   the fetch/decode stage and accepts one GPR write plus one HI/LO write from write-back.
// - Holds the 32 x 32-bit MIPS GPRs ($0 hard-wired to zero) and the HI/LO pair.
// - Write-to-read bypass: a value written this cycle is visible to a same-cycle read.

---
 rtl/reg_file.sv | 89 ++++++++
 tb/tb_reg_file.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 32 x 32-bit MIPS GPR file with HI/LO, two bypassed read ports
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r1_en,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [DATA_W-1:0] r1_data,
  input  logic              r2_en,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r2_data,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_q [DEPTH];
  logic [DATA_W-1:0] gpr_d [DEPTH];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic w_live;
  assign w_live = w_en && (w_addr != '0);

  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (w_live) begin
      gpr_d[w_addr] = w_data;
    end
    if (hilo_we) begin
      hi_d = hi_wdata;
      lo_d = lo_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Same-cycle write data wins over stored contents; $0 never bypasses.
  always_comb begin
    r1_data = '0;
    r2_data = '0;
    if (!rst && r1_en && (r1_addr != '0)) begin
      r1_data = (w_live && (w_addr == r1_addr)) ? w_data : gpr_q[r1_addr];
    end
    if (!rst && r2_en && (r2_addr != '0)) begin
      r2_data = (w_live && (w_addr == r2_addr)) ? w_data : gpr_q[r2_addr];
    end
  end

  always_comb begin
    hi_rdata = '0;
    lo_rdata = '0;
    if (!rst) begin
      hi_rdata = hilo_we ? hi_wdata : hi_q;
      lo_rdata = hilo_we ? lo_wdata : lo_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : directed vector table plus randomized run against an array model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        r1_en, r2_en, w_en, hilo_we;
  logic [4:0]  r1_addr, r2_addr, w_addr;
  logic [31:0] w_data, hi_wdata, lo_wdata;
  logic [31:0] r1_data, r2_data, hi_rdata, lo_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .r1_en(r1_en), .r1_addr(r1_addr), .r1_data(r1_data),
    .r2_en(r2_en), .r2_addr(r2_addr), .r2_data(r2_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  // Reference model: plain array updated by the architectural write rules.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] <= 32'h0;
      m_hi <= 32'h0;
      m_lo <= 32'h0;
    end else begin
      if (w_en && w_addr != 5'd0) m_gpr[w_addr] <= w_data;
      if (hilo_we) begin
        m_hi <= hi_wdata;
        m_lo <= lo_wdata;
      end
    end
  end

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] addr);
    if (rst || !en || addr == 5'd0) return 32'h0;
    if (w_en && w_addr == addr) return w_data;
    return m_gpr[addr];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        r1_en;
    logic [4:0]  r1_addr;
    logic        r2_en;
    logic [4:0]  r2_addr;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        hilo_we;
    logic [31:0] hi_w;
    logic [31:0] lo_w;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t tbl_a [2];
  vec_t tbl_b [12];

  task automatic drive(input vec_t v);
    rst = v.rst; r1_en = v.r1_en; r1_addr = v.r1_addr;
    r2_en = v.r2_en; r2_addr = v.r2_addr;
    w_en = v.w_en; w_addr = v.w_addr; w_data = v.w_data;
    hilo_we = v.hilo_we; hi_wdata = v.hi_w; lo_wdata = v.lo_w;
  endtask

  // Inputs change at posedge+1, outputs checked at the following negedge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #4;
    chk({tag, ".r1"}, r1_data, v.e_r1);
    chk({tag, ".r2"}, r2_data, v.e_r2);
    chk({tag, ".hi"}, hi_rdata, v.e_hi);
    chk({tag, ".lo"}, lo_rdata, v.e_lo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // rst r1e r1a r2e r2a we wa wd hwe hi lo | r1 r2 hi lo
    tbl_a[0] = '{1, 1, 5'd1, 1, 5'd2, 1, 5'd4, 32'h55, 1, 32'h1, 32'h2, 0, 0, 0, 0};
    tbl_a[1] = '{1, 1, 5'd4, 1, 5'd4, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 0};

    tbl_b[0]  = '{0, 1, 5'd5, 1, 5'd6, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0};
    tbl_b[1]  = '{0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl_b[2]  = '{0, 1, 5'd7, 1, 5'd7, 1, 5'd7, 32'h1234, 0, 0, 0, 32'h1234, 32'h1234, 0, 0};
    tbl_b[3]  = '{0, 1, 5'd7, 1, 5'd5, 0, 5'd7, 32'h9999, 0, 0, 0, 32'h1234, 32'hDEADBEEF, 0, 0};
    tbl_b[4]  = '{0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0};
    tbl_b[5]  = '{0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0};
    tbl_b[6]  = '{0, 0, 5'd5, 1, 5'd5, 0, 5'd0, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tbl_b[7]  = '{0, 0, 5'd9, 1, 5'd9, 1, 5'd9, 32'h99, 0, 0, 0, 0, 32'h99, 0, 0};
    tbl_b[8]  = '{0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0, 1, 32'hA, 32'hB, 0, 0, 32'hA, 32'hB};
    tbl_b[9]  = '{0, 1, 5'd9, 0, 5'd0, 0, 5'd0, 32'h0, 0, 32'hE, 32'hF, 32'h99, 0, 32'hA, 32'hB};
    tbl_b[10] = '{1, 1, 5'd3, 1, 5'd5, 1, 5'd3, 32'h3333, 1, 32'hC, 32'hD, 0, 0, 0, 0};
    tbl_b[11] = '{0, 1, 5'd3, 1, 5'd5, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0};

    drive(tbl_a[1]);
    #1;
    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("rst%0d", i));

    // Post-reset sweep: every register must read zero on both ports.
    for (int a = 1; a < 32; a++) begin
      v = '{0, 1, a[4:0], 1, a[4:0], 0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0};
      apply(v, $sformatf("clr%0d", a));
    end

    foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("vec%0d", i));

    // Randomized run against the model; small address range to force bypass hits.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      r1_en    = ($urandom_range(0, 7) != 0);
      r2_en    = ($urandom_range(0, 7) != 0);
      r1_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
      r2_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
      w_en     = ($urandom_range(0, 1) != 0);
      w_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
      w_data   = $urandom;
      hilo_we  = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      #4;
      chk("rnd.r1", r1_data, m_read(r1_en, r1_addr));
      chk("rnd.r2", r2_data, m_read(r2_en, r2_addr));
      chk("rnd.hi", hi_rdata, rst ? 32'h0 : (hilo_we ? hi_wdata : m_hi));
      chk("rnd.lo", lo_rdata, rst ? 32'h0 : (hilo_we ? lo_wdata : m_lo));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
